// File: rtl/id_stage_hold_ctrl_pkg.sv
// id_stage_hold_ctrl_pkg: shared constants and types for the IF/ID hold controller.
package id_stage_hold_ctrl_pkg;

   localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

   typedef enum logic {HOLD_RUN, HOLD_STALL} hold_state_e;

endpackage

// File: rtl/id_stage_hold_ctrl.sv
// id_stage_hold_ctrl: owns the IF/ID register, turns stall/flush into pipeline action and keeps perf counters.
module id_stage_hold_ctrl
   import id_stage_hold_ctrl_pkg::*;
#(
   parameter int DATA_W    = 32,
   parameter int CNT_W     = 32,
   parameter int MAX_STALL = 3
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              stall_ip,
   input  logic              flush_ip,
   input  logic [DATA_W-1:0] IF_instr_ip,
   input  logic [DATA_W-1:0] IF_pc_ip,
   input  logic              IF_valid_ip,
   output logic [DATA_W-1:0] ID_instr_op,
   output logic [DATA_W-1:0] ID_pc_op,
   output logic              ID_valid_op,
   output logic              pc_en_op,
   output logic              EX_bubble_op,
   output logic [CNT_W-1:0]  stall_cycles_op,
   output logic [CNT_W-1:0]  flush_count_op,
   output logic              stall_overrun_op
);

   localparam int RUN_W = $clog2(MAX_STALL + 1) + 1;

   hold_state_e       state_q, state_d;
   logic [RUN_W-1:0]  run_q, run_d;
   logic [DATA_W-1:0] instr_q, instr_d, pc_q, pc_d;
   logic              valid_q, valid_d, ovr_q, ovr_d;
   logic [CNT_W-1:0]  stall_cnt_q, flush_cnt_q;

   assign pc_en_op         = ~stall_ip | flush_ip;
   assign EX_bubble_op     = stall_ip | flush_ip;
   assign ID_instr_op      = instr_q;
   assign ID_pc_op         = pc_q;
   assign ID_valid_op      = valid_q;
   assign stall_cycles_op  = stall_cnt_q;
   assign flush_count_op   = flush_cnt_q;
   assign stall_overrun_op = ovr_q;

   always_comb begin
      state_d = HOLD_RUN;
      run_d   = '0;
      instr_d = IF_instr_ip;
      pc_d    = IF_pc_ip;
      valid_d = IF_valid_ip;
      ovr_d   = ovr_q;
      if (flush_ip) begin
         instr_d = DATA_W'(NOP_INSTR);
         pc_d    = '0;
         valid_d = 1'b0;
      end else if (stall_ip) begin
         instr_d = instr_q;
         pc_d    = pc_q;
         valid_d = valid_q;
         state_d = HOLD_STALL;
         // a run only continues if the previous cycle was also a stall
         run_d   = (state_q == HOLD_RUN) ? RUN_W'(1) : (&run_q ? run_q : run_q + RUN_W'(1));
         ovr_d   = ovr_q | (run_q == RUN_W'(MAX_STALL));
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= HOLD_RUN;
         run_q   <= '0;
         instr_q <= DATA_W'(NOP_INSTR);
         pc_q    <= '0;
         valid_q <= 1'b0;
         ovr_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         run_q   <= run_d;
         instr_q <= instr_d;
         pc_q    <= pc_d;
         valid_q <= valid_d;
         ovr_q   <= ovr_d;
      end
   end

   always_ff @(posedge clk) begin
      if (reset)
         stall_cnt_q <= '0;
      else if (stall_ip && !flush_ip && !(&stall_cnt_q))
         stall_cnt_q <= stall_cnt_q + CNT_W'(1);
   end

   always_ff @(posedge clk) begin
      if (reset)
         flush_cnt_q <= '0;
      else if (flush_ip && !(&flush_cnt_q))
         flush_cnt_q <= flush_cnt_q + CNT_W'(1);
   end

endmodule

// File: tb/tb_id_stage_hold_ctrl.sv
// tb_id_stage_hold_ctrl: directed checks of IF/ID hold, flush, counters and overrun flag.
module tb_id_stage_hold_ctrl;

   logic        clk = 1'b0;
   logic        reset, stall_ip, flush_ip, IF_valid_ip;
   logic [31:0] IF_instr_ip, IF_pc_ip;
   logic [31:0] ID_instr_op, ID_pc_op, stall_cycles_op, flush_count_op;
   logic        ID_valid_op, pc_en_op, EX_bubble_op, stall_overrun_op;
   int          errors = 0;
   int          checks = 0;

   id_stage_hold_ctrl dut (
      .clk(clk), .reset(reset), .stall_ip(stall_ip), .flush_ip(flush_ip),
      .IF_instr_ip(IF_instr_ip), .IF_pc_ip(IF_pc_ip), .IF_valid_ip(IF_valid_ip),
      .ID_instr_op(ID_instr_op), .ID_pc_op(ID_pc_op), .ID_valid_op(ID_valid_op),
      .pc_en_op(pc_en_op), .EX_bubble_op(EX_bubble_op),
      .stall_cycles_op(stall_cycles_op), .flush_count_op(flush_count_op),
      .stall_overrun_op(stall_overrun_op)
   );

   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic s, input logic f, input logic [31:0] ins, input logic [31:0] pc);
      stall_ip    = s;
      flush_ip    = f;
      IF_instr_ip = ins;
      IF_pc_ip    = pc;
      IF_valid_ip = 1'b1;
      #1;
   endtask

   initial begin
      reset = 1'b1;
      drive(0, 0, 32'h1234_5678, 32'h10);
      tick;
      drive(0, 0, 32'hdead_beef, 32'h14);
      tick;
      chk("rst_instr", ID_instr_op, 32'h13);
      chk("rst_pc", ID_pc_op, 0);
      chk("rst_valid", 32'(ID_valid_op), 0);
      chk("rst_stall_cnt", stall_cycles_op, 0);
      chk("rst_flush_cnt", flush_count_op, 0);
      chk("rst_ovr", 32'(stall_overrun_op), 0);

      reset = 1'b0;
      drive(0, 0, 32'h0020_8033, 32'h40);
      chk("adv_pc_en", 32'(pc_en_op), 1);
      chk("adv_bubble", 32'(EX_bubble_op), 0);
      tick;
      chk("adv_instr", ID_instr_op, 32'h0020_8033);
      chk("adv_pc", ID_pc_op, 32'h40);
      chk("adv_valid", 32'(ID_valid_op), 1);

      for (int i = 0; i < 3; i++) begin
         drive(1, 0, 32'h1111_0000 + 32'(i), 32'h44 + 32'(4 * i));
         chk("st_pc_en", 32'(pc_en_op), 0);
         chk("st_bubble", 32'(EX_bubble_op), 1);
         tick;
         chk("st_hold_instr", ID_instr_op, 32'h0020_8033);
         chk("st_hold_pc", ID_pc_op, 32'h40);
      end
      chk("st3_cnt", stall_cycles_op, 3);
      chk("st3_ovr", 32'(stall_overrun_op), 0);
      drive(0, 0, 32'h2222_2222, 32'h50);
      tick;
      chk("rel_instr", ID_instr_op, 32'h2222_2222);
      chk("rel_pc", ID_pc_op, 32'h50);
      chk("rel_cnt", stall_cycles_op, 3);

      for (int i = 0; i < 4; i++) begin
         drive(1, 0, 32'h3333_0000 + 32'(i), 32'h60);
         tick;
         if (i == 2) chk("ov_before", 32'(stall_overrun_op), 0);
      end
      chk("ov_set", 32'(stall_overrun_op), 1);
      chk("ov_cnt", stall_cycles_op, 7);
      chk("ov_hold_instr", ID_instr_op, 32'h2222_2222);
      drive(0, 0, 32'h4444_4444, 32'h70);
      tick;
      chk("ov_sticky", 32'(stall_overrun_op), 1);

      drive(1, 1, 32'h5555_5555, 32'h80);
      chk("fl_pc_en", 32'(pc_en_op), 1);
      chk("fl_bubble", 32'(EX_bubble_op), 1);
      tick;
      chk("fl_instr", ID_instr_op, 32'h13);
      chk("fl_pc", ID_pc_op, 0);
      chk("fl_valid", 32'(ID_valid_op), 0);
      chk("fl_cnt", flush_count_op, 1);
      chk("fl_stall_cnt", stall_cycles_op, 7);
      chk("fl_ovr_kept", 32'(stall_overrun_op), 1);

      drive(1, 0, 32'h6666_6666, 32'h90);
      tick;
      chk("rm_cnt1", stall_cycles_op, 8);
      reset = 1'b1;
      drive(1, 0, 32'h6666_6667, 32'h94);
      chk("rm_pc_en", 32'(pc_en_op), 0);
      chk("rm_bubble", 32'(EX_bubble_op), 1);
      tick;
      chk("rm_instr", ID_instr_op, 32'h13);
      chk("rm_valid", 32'(ID_valid_op), 0);
      chk("rm_stall_cnt", stall_cycles_op, 0);
      chk("rm_flush_cnt", flush_count_op, 0);
      chk("rm_ovr", 32'(stall_overrun_op), 0);
      reset = 1'b0;
      drive(1, 0, 32'h7777_7777, 32'ha0);
      tick;
      drive(0, 0, 32'h8888_8888, 32'ha4);
      tick;
      chk("rm_one_stall", stall_cycles_op, 1);
      chk("rm_load", ID_instr_op, 32'h8888_8888);

      for (int i = 0; i < 2; i++) begin
         drive(1, 0, 32'h9999_9999, 32'hb0);
         tick;
      end
      drive(1, 1, 32'h9999_9999, 32'hb0);
      tick;
      for (int i = 0; i < 3; i++) begin
         drive(1, 0, 32'haaaa_aaaa, 32'hc0);
         tick;
      end
      chk("fl_restart_ovr", 32'(stall_overrun_op), 0);
      chk("fl_restart_cnt", stall_cycles_op, 6);
      drive(0, 0, 32'hbbbb_bbbb, 32'hd0);
      tick;
      for (int i = 0; i < 3; i++) begin
         drive(1, 0, 32'hcccc_cccc, 32'he0);
         tick;
      end
      chk("adv_restart_ovr", 32'(stall_overrun_op), 0);
      chk("adv_restart_hold", ID_instr_op, 32'hbbbb_bbbb);
      drive(1, 0, 32'hcccc_cccc, 32'he0);
      tick;
      chk("adv_restart_ovr4", 32'(stall_overrun_op), 1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
